// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and read-mode encodings for fifo_sync_param
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 6;

  localparam bit FIFO_MODE_STD  = 1'b0;
  localparam bit FIFO_MODE_FWFT = 1'b1;

endpackage

// File: rtl/fifo_mem_sdp.sv
// rtl/fifo_mem_sdp.sv - simple dual-port RAM, synchronous write, asynchronous read
module fifo_mem_sdp
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with thresholds, FWFT mode and sticky error flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = 60,
  parameter int AE_THRESH = 4,
  parameter bit FWFT      = FIFO_MODE_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the pre-edge count, so full+read drops the write and empty+write flags underflow.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  fifo_mem_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data  = mem_rd_data;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            rd_data_q <= mem_rd_data;
          end
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock, parametrised FIFO. Generalises the team's fixed 8-bit x 64 FIFO in data width and depth.
- Adds programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Used as the standard intra-domain buffer between producer/consumer blocks.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W (default 64 words).
- AF_THRESH, 60, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT: acknowledge/pop of head word).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a valid popped/head word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_W+1  number of stored words.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1 at an edge):
  - wr_ptr, rd_ptr and count go to 0. empty=1; full=0; almost_empty=1; almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - wr_en/rd_en are ignored in any cycle where rst=1.
  - Reset mid-operation discards all stored data.
- Write acceptance: wr_acc = wr_en & !full.
  - On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr increments mod DEPTH.
  - wr_en & full: the write is dropped and overflow <= 1.
- Read acceptance: rd_acc = rd_en & !empty.
  - On rd_acc: rd_ptr increments mod DEPTH.
  - rd_en & empty: no pop, and underflow <= 1.
- full/empty use the pre-edge count. A simultaneous read+write on full therefore pops and drops the write. A simultaneous read+write on empty stores the word and flags underflow.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- Flags full, empty, almost_* are combinational decodes of the count register (no extra latency). overflow/underflow are sticky until rst.
- FWFT=0:
  - Latency 1: rd_data <= mem[rd_ptr] and rd_valid <= 1 at the edge where rd_acc.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the current head; the next head appears the following cycle.
  - A word written to an empty FIFO at edge N is visible (rd_valid=1) during cycle N+1.
- Pointer wrap is natural ADDR_W-bit rollover. Ordering is preserved across wrap.

Decomposition:
- Shared package fifo_pkg holds the default constants (FIFO_DATA_W=8, FIFO_ADDR_W=6) and the FWFT mode encodings (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1).
- One sub-module, fifo_mem_sdp: simple dual-port RAM, DEPTH x DATA_W, synchronous write, asynchronous read. Pointers, count, flags and output register stay in the top.

Test Plan (defaults unless stated):
1. Reset, then write 0x01..0x40 on 64 consecutive cycles -> almost_full rises after the 60th write; after the 64th, full=1 and count=64. A 65th write of 0xFF -> overflow=1, count stays 64, 0xFF is never read back.
2. From full (FWFT=0), assert rd_en for 65 cycles -> rd_data=0x01..0x40, each one cycle after its rd_en, with rd_valid=1. On the 65th: underflow=1, rd_valid=0, rd_data holds 0x40, empty=1, count=0.
3. Simultaneous rd_en+wr_en:
   - at count=10 -> count stays 10;
   - at full -> read accepted, write dropped, count=63, overflow=1;
   - at empty -> write accepted, count=1, underflow=1.
4. Stream 200 words (0x00..0xC7) with wr_en and rd_en both high after a 5-word prefill -> output sequence is exact and in order across three pointer wraps; count constant at 5.
5. FWFT=1: write 0xA5 then 0x3C into an empty FIFO -> cycle after the first write: rd_valid=1, rd_data=0xA5 with no rd_en. Pulse rd_en -> next cycle rd_data=0x3C. A second pop -> rd_valid=0, empty=1.
6. Fill to count=20, then pulse rst for one cycle while wr_en=rd_en=1 -> next cycle count=0, empty=1, almost_empty=1, overflow=underflow=0, rd_valid=0.
